// File: rtl/multicycle_core_param.sv
`timescale 1ns/1ps
// multicycle_core_param
//   Parametrised multicycle processor core. A single FSM sequences one
//   instruction at a time through FETCH / DECODE / EXEC / MEM / WB, sharing a
//   single datapath. Holds instruction memory, data memory, register file,
//   ALU and branch unit. Instruction memory is written through the program
//   port while the core is held in IDLE.
//
// Ports
//   clk        : single clock, rising-edge state updates
//   reset      : asynchronous, active-low reset
//   prog_mode  : 1 = hold core in IDLE and enable the program port
//   prog_we    : instruction-memory write strobe (honoured in IDLE with prog_mode=1)
//   prog_addr  : instruction-memory write address
//   prog_data  : instruction word to write
//   alu_out    : registered ALU result
//   pc         : current program counter
//   halted     : high while in HALT
//   state      : FSM state encoding (debug)
//
// Instruction format, MSB first: opcode[3:0], rd, rs1, rs2, imm.
module multicycle_core_param #(
  parameter int DATA_W  = 24,
  parameter int REG_AW  = 5,
  parameter int IMM_W   = 8,
  parameter int PC_W    = 10,
  parameter int DADDR_W = 10,
  parameter int INSTR_W = 4 + 3*REG_AW + IMM_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_mode,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [DATA_W-1:0]  alu_out,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_ADDI = 4'd6,
    OP_LI   = 4'd7,
    OP_LD   = 4'd8,
    OP_ST   = 4'd9,
    OP_JMP  = 4'd10,
    OP_BNZ  = 4'd11,
    OP_HALT = 4'd12
  } opcode_t;

  // Storage (not reset)
  logic [INSTR_W-1:0] imem [2**PC_W];
  logic [DATA_W-1:0]  dmem [2**DADDR_W];
  logic [DATA_W-1:0]  rf   [2**REG_AW];

  // Architectural / pipeline registers
  state_t             state_q, state_next;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  a_q, b_q, mdr;

  // Decoded instruction fields
  logic [3:0]         opcode;
  logic [REG_AW-1:0]  rd, rs1, rs2;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  simm;
  logic [PC_W-1:0]    br_off;

  // Datapath combinational results
  logic [DATA_W-1:0]  exec_result;
  logic [DATA_W-1:0]  wb_data;
  logic [DADDR_W-1:0] mem_addr;
  logic               take_branch;
  logic [DATA_W-1:0]  rf_a, rf_b;

  assign opcode = ir[INSTR_W-1 -: 4];
  assign rd     = ir[INSTR_W-5 -: REG_AW];
  assign rs1    = ir[INSTR_W-5-REG_AW -: REG_AW];
  assign rs2    = ir[IMM_W+REG_AW-1 -: REG_AW];
  assign imm    = ir[IMM_W-1:0];

  // Sized casts of a signed value sign-extend (or truncate) to the target width.
  assign simm   = DATA_W'($signed(imm));
  assign br_off = PC_W'($signed(imm));

  assign mem_addr = alu_out[DADDR_W-1:0];
  assign wb_data  = (opcode == OP_LD) ? mdr : alu_out;

  // Register 0 reads as zero regardless of array contents.
  assign rf_a = (rs1 == '0) ? '0 : rf[rs1];
  assign rf_b = (rs2 == '0) ? '0 : rf[rs2];

  assign state = state_q;

  // ALU / address unit
  always_comb begin
    exec_result = alu_out;
    take_branch = 1'b0;
    case (opcode)
      OP_ADD:  exec_result = a_q + b_q;
      OP_SUB:  exec_result = a_q - b_q;
      OP_AND:  exec_result = a_q & b_q;
      OP_OR:   exec_result = a_q | b_q;
      OP_XOR:  exec_result = a_q ^ b_q;
      OP_ADDI: exec_result = a_q + simm;
      OP_LI:   exec_result = simm;
      OP_LD,
      OP_ST:   exec_result = b_q + simm;
      OP_JMP:  take_branch = 1'b1;
      OP_BNZ:  take_branch = (a_q != '0);
      default: ;
    endcase
  end

  // Next-state logic; prog_mode overrides every transition.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE:   if (!prog_mode) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LI:
            state_next = S_WB;
          OP_LD, OP_ST:
            state_next = S_MEM;
          default:
            state_next = S_FETCH;
        endcase
      end
      S_MEM:    state_next = (opcode == OP_LD) ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
    if (prog_mode) state_next = S_IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      halted  <= 1'b0;
    end else begin
      state_q <= state_next;
      halted  <= (state_next == S_HALT);
    end
  end

  // Datapath registers. With prog_mode high nothing but the FSM moves, so an
  // in-flight instruction is abandoned without side effects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mdr     <= '0;
      alu_out <= '0;
    end else if (!prog_mode) begin
      case (state_q)
        S_IDLE: pc <= '0;
        S_FETCH: begin
          ir <= imem[pc];
          pc <= pc + PC_W'(1);
        end
        S_DECODE: begin
          a_q <= rf_a;
          b_q <= rf_b;
        end
        S_EXEC: begin
          alu_out <= exec_result;
          // pc already points past this instruction, so offsets are relative to it.
          if (take_branch) pc <= pc + br_off;
        end
        S_MEM: begin
          if (opcode == OP_LD) mdr <= dmem[mem_addr];
        end
        default: ;
      endcase
    end
  end

  // Instruction memory program port
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && prog_mode && prog_we)
      imem[prog_addr] <= prog_data;
  end

  // Register file write-back; writes to register 0 are dropped.
  always_ff @(posedge clk) begin
    if (state_q == S_WB && !prog_mode && rd != '0)
      rf[rd] <= wb_data;
  end

  // Data memory store
  always_ff @(posedge clk) begin
    if (state_q == S_MEM && !prog_mode && opcode == OP_ST)
      dmem[mem_addr] <= a_q;
  end

endmodule

// File: tb/tb_multicycle_core_param.sv
`timescale 1ns/1ps
// Scoreboard bench for multicycle_core_param: directed programs are loaded
// through the program port; expected fetch addresses, per-instruction cycle
// counts and ALU results are queued, and a negedge monitor pops and compares
// them as the core produces them.
module tb_multicycle_core_param;

  localparam int DATA_W  = 24;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 27;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_EXEC = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

  logic               clk = 1'b0;
  logic               reset;
  logic               prog_mode;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [DATA_W-1:0]  alu_out;
  logic [PC_W-1:0]    pc;
  logic               halted;
  logic [2:0]         state;

  multicycle_core_param #(
    .DATA_W(24), .REG_AW(5), .IMM_W(8), .PC_W(10), .DADDR_W(10), .INSTR_W(27)
  ) dut (
    .clk(clk), .reset(reset), .prog_mode(prog_mode), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .alu_out(alu_out),
    .pc(pc), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_alu_q[$];
  int                exp_pc_q[$];
  int                exp_cpi_q[$];

  bit         mon_en = 1'b0;
  int         mon_cyc = 0;
  int         last_fetch = -1;
  logic [2:0] prev_state = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=missing required=present", name);
  endtask

  function automatic logic [INSTR_W-1:0] enc(input int op, input int rd, input int rs1,
                                             input int rs2, input int imm);
    return {op[3:0], rd[4:0], rs1[4:0], rs2[4:0], imm[7:0]};
  endfunction

  // Monitor: fetch address, fetch-to-fetch cycle count, and EXEC result.
  always @(negedge clk) begin
    if (!mon_en || state == ST_IDLE) last_fetch = -1;
    if (mon_en) begin
      mon_cyc++;
      if (state == ST_FETCH) begin
        if (last_fetch >= 0) begin
          if (exp_cpi_q.size() == 0) flag("cpi_underflow");
          else check("cpi", mon_cyc - last_fetch, exp_cpi_q.pop_front());
        end
        last_fetch = mon_cyc;
        if (exp_pc_q.size() == 0) flag("fetch_pc_underflow");
        else check("fetch_pc", 32'(pc), exp_pc_q.pop_front());
      end
      if (state == ST_HALT && prev_state != ST_HALT) begin
        if (last_fetch >= 0) begin
          if (exp_cpi_q.size() == 0) flag("halt_cpi_underflow");
          else check("halt_cpi", mon_cyc - last_fetch, exp_cpi_q.pop_front());
        end
        last_fetch = -1;
      end
      if ((state == ST_WB || state == ST_MEM) && prev_state == ST_EXEC) begin
        if (exp_alu_q.size() == 0) flag("alu_underflow");
        else check("alu_out", 32'(alu_out), 32'(exp_alu_q.pop_front()));
      end
    end
    prev_state = state;
  end

  task automatic wr(input int addr, input logic [INSTR_W-1:0] ins);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr[PC_W-1:0];
    prog_data = ins;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  // Release the core, wait (bounded) for HALT, check timing and frozen state,
  // then return to IDLE. we_noise keeps prog_we asserted while running.
  task automatic run(input string name, input int halt_pc, input int cycles, input bit we_noise);
    int n = 0;
    @(negedge clk);
    mon_en    = 1'b1;
    prog_mode = 1'b0;
    prog_we   = we_noise;
    prog_addr = 10'd3;
    prog_data = enc(0, 0, 0, 0, 0);
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!halted) flag({name, "_halt_timeout"});
    check({name, "_cycles"}, n, cycles);
    check({name, "_halt_pc"}, 32'(pc), halt_pc);
    check({name, "_state_halt"}, 32'(state), 32'(ST_HALT));
    repeat (3) @(negedge clk);
    check({name, "_pc_frozen"}, 32'(pc), halt_pc);
    check({name, "_halted_hold"}, 32'(halted), 1);
    prog_we   = 1'b0;
    prog_mode = 1'b1;
    @(negedge clk);
    check({name, "_halted_clr"}, 32'(halted), 0);
    check({name, "_state_idle"}, 32'(state), 32'(ST_IDLE));
    mon_en = 1'b0;
    check({name, "_queues_empty"}, exp_alu_q.size() + exp_pc_q.size() + exp_cpi_q.size(), 0);
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    prog_mode = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    #2;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_pc", 32'(pc), 0);
    check("rst_alu", 32'(alu_out), 0);
    check("rst_halted", 32'(halted), 0);
    #1 reset = 1'b1;

    // LI r1,5; LI r2,-3; ADD r3,r1,r2; HALT
    wr(0, enc(7, 1, 0, 0, 5));
    wr(1, enc(7, 2, 0, 0, -3));
    wr(2, enc(1, 3, 1, 2, 0));
    wr(3, enc(12, 0, 0, 0, 0));

    // Asynchronous reset while the ADD is in EXEC
    @(negedge clk);
    prog_mode = 1'b0;
    n = 0;
    while (!(state == ST_EXEC && pc == 10'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) flag("exec_wait_timeout");
    #1 reset = 1'b0;
    prog_mode = 1'b1;
    #0.5;
    check("async_rst_state", 32'(state), 32'(ST_IDLE));
    check("async_rst_pc", 32'(pc), 0);
    check("async_rst_alu", 32'(alu_out), 0);
    check("async_rst_halted", 32'(halted), 0);
    #0.5 reset = 1'b1;

    // Same program end to end; prog_we held during the run must be ignored.
    exp_pc_q  = {0, 1, 2, 3};
    exp_cpi_q = {4, 4, 4, 2};
    exp_alu_q = {24'h000005, 24'hFFFFFD, 24'h000002};
    run("li_add", 4, 15, 1'b1);

    // Store / load round trip through dmem[6]
    wr(0, enc(7, 1, 0, 0, 8'h55));
    wr(1, enc(7, 2, 0, 0, 4));
    wr(2, enc(9, 0, 1, 2, 2));
    wr(3, enc(8, 4, 0, 2, 2));
    wr(4, enc(1, 5, 4, 0, 0));
    wr(5, enc(12, 0, 0, 0, 0));
    exp_pc_q  = {0, 1, 2, 3, 4, 5};
    exp_cpi_q = {4, 4, 4, 5, 4, 2};
    exp_alu_q = {24'h55, 24'h4, 24'h6, 24'h6, 24'h55};
    run("st_ld", 6, 24, 1'b0);

    // Countdown loop: LI r1,3; ADDI r1,r1,-1; BNZ r1,-2; HALT
    wr(0, enc(7, 1, 0, 0, 3));
    wr(1, enc(6, 1, 1, 0, -1));
    wr(2, enc(11, 0, 1, 0, -2));
    wr(3, enc(12, 0, 0, 0, 0));
    exp_pc_q  = {0, 1, 2, 1, 2, 1, 2, 3};
    exp_cpi_q = {4, 4, 3, 4, 3, 4, 3, 2};
    exp_alu_q = {24'h3, 24'h2, 24'h1, 24'h0};
    run("loop", 4, 28, 1'b0);

    // Zero register: LI r0,7; ADD r1,r0,r0; LI r7,0; HALT
    wr(0, enc(7, 0, 0, 0, 7));
    wr(1, enc(1, 1, 0, 0, 0));
    wr(2, enc(7, 7, 0, 0, 0));
    wr(3, enc(12, 0, 0, 0, 0));
    exp_pc_q  = {0, 1, 2, 3};
    exp_cpi_q = {4, 4, 4, 2};
    exp_alu_q = {24'h7, 24'h0, 24'h0};
    run("r0", 4, 15, 1'b0);

    // PC wrap: 0 BNZ r7,+1; 1 JMP -5 (->1021); 2 HALT;
    // 1021 LI r7,1; 1022 JMP +1 (->0); 1023 LI r7,0 (must be skipped)
    wr(0,    enc(11, 0, 7, 0, 1));
    wr(1,    enc(10, 0, 0, 0, -5));
    wr(2,    enc(12, 0, 0, 0, 0));
    wr(1021, enc(7, 7, 0, 0, 1));
    wr(1022, enc(10, 0, 0, 0, 1));
    wr(1023, enc(7, 7, 0, 0, 0));
    exp_pc_q  = {0, 1, 1021, 1022, 0, 2};
    exp_cpi_q = {3, 3, 4, 3, 3, 2};
    exp_alu_q = {24'h1};
    run("wrap", 3, 19, 1'b0);

    // Logic ops: LI r1,0x3C; LI r2,-1; SUB; AND; OR; XOR; HALT
    wr(0, enc(7, 1, 0, 0, 8'h3C));
    wr(1, enc(7, 2, 0, 0, -1));
    wr(2, enc(2, 3, 1, 2, 0));
    wr(3, enc(3, 4, 1, 2, 0));
    wr(4, enc(4, 5, 1, 2, 0));
    wr(5, enc(5, 6, 1, 2, 0));
    wr(6, enc(12, 0, 0, 0, 0));
    exp_pc_q  = {0, 1, 2, 3, 4, 5, 6};
    exp_cpi_q = {4, 4, 4, 4, 4, 4, 2};
    exp_alu_q = {24'h00003C, 24'hFFFFFF, 24'h00003D, 24'h00003C, 24'hFFFFFF, 24'hFFFFC3};
    run("logic", 7, 27, 1'b0);

    // Abort during WB of ADD r1,r1,r2: r1 must keep 9.
    wr(0, enc(7, 1, 0, 0, 9));
    wr(1, enc(7, 2, 0, 0, 1));
    wr(2, enc(1, 1, 1, 2, 0));
    wr(3, enc(12, 0, 0, 0, 0));
    exp_pc_q  = {0, 1, 2};
    exp_cpi_q = {4, 4};
    exp_alu_q = {24'h9, 24'h1, 24'hA};
    @(negedge clk);
    mon_en    = 1'b1;
    prog_mode = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_in_wb", 32'(state), 32'(ST_WB));
    prog_mode = 1'b1;
    @(negedge clk);
    check("abort_state_idle", 32'(state), 32'(ST_IDLE));
    check("abort_halted", 32'(halted), 0);
    mon_en = 1'b0;
    check("abort_queues_empty", exp_alu_q.size() + exp_pc_q.size() + exp_cpi_q.size(), 0);

    // ADD r3,r1,r0; NOP; undefined op 14; HALT
    wr(0, enc(1, 3, 1, 0, 0));
    wr(1, enc(0, 0, 0, 0, 0));
    wr(2, enc(14, 9, 9, 9, 8'hAA));
    wr(3, enc(12, 0, 0, 0, 0));
    exp_pc_q  = {0, 1, 2, 3};
    exp_cpi_q = {4, 3, 3, 2};
    exp_alu_q = {24'h9};
    run("post_abort", 4, 13, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
